// File: rtl/regfile_sb.sv
// Integer register file with a write-back scoreboard.
// Combinational reads, synchronous writes and busy-bit updates. Busy bits track outstanding
// long-latency (load) writes so decode can stall on RAW/WAW hazards.
// Optional feature macro: REGFILE_WR_BYPASS_EN. When it is defined, a same-cycle write-back
// is forwarded to the read ports and its busy clear ends the stall in that same cycle.
module regfile_sb #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned REG_NUM       = 32,
   parameter int unsigned REG_IDX_WIDTH = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
   input  logic                     rs1_en_i,
   input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
   input  logic                     rs2_en_i,
   output logic [XLEN-1:0]          rs1_rdata_o,
   output logic [XLEN-1:0]          rs2_rdata_o,
   input  logic                     iss_valid_i,
   input  logic [REG_IDX_WIDTH-1:0] iss_rd_idx_i,
   input  logic                     iss_rd_en_i,
   input  logic                     iss_long_i,
   input  logic                     wb_we_i,
   input  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_i,
   input  logic [XLEN-1:0]          wb_wdata_i,
   input  logic                     wb_long_i,
   input  logic                     flush_i,
   output logic                     stall_o
);

   logic [XLEN-1:0]    regs_q [REG_NUM];
   logic [XLEN-1:0]    regs_d [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;

   logic wb_wr_en;
   logic wb_clr;
   logic clr1, clr2, clr_rd;
   logic hz1, hz2, waw;
   logic iss_set;

   assign wb_wr_en = wb_we_i && (wb_rd_idx_i != '0);
   assign wb_clr   = wb_we_i && wb_long_i;

`ifdef REGFILE_WR_BYPASS_EN
   // A retiring load releases its dependants in the write-back cycle itself.
   assign clr1   = wb_clr && (wb_rd_idx_i == rs1_idx_i);
   assign clr2   = wb_clr && (wb_rd_idx_i == rs2_idx_i);
   assign clr_rd = wb_clr && (wb_rd_idx_i == iss_rd_idx_i);
`else
   assign clr1   = 1'b0;
   assign clr2   = 1'b0;
   assign clr_rd = 1'b0;
`endif

   assign hz1 = rs1_en_i && (rs1_idx_i != '0) && busy_q[rs1_idx_i] && !clr1;
   assign hz2 = rs2_en_i && (rs2_idx_i != '0) && busy_q[rs2_idx_i] && !clr2;
   assign waw = iss_valid_i && iss_rd_en_i && (iss_rd_idx_i != '0) && busy_q[iss_rd_idx_i]
                && !clr_rd;

   // Masked by reset and flush so decode never holds while the pipeline is being cleared.
   assign stall_o = (hz1 || hz2 || waw) && rst_n_i && !flush_i;

   assign iss_set = iss_valid_i && !stall_o && iss_rd_en_i && iss_long_i
                    && (iss_rd_idx_i != '0);

   // Read ports: array, optionally overridden by same-cycle write-back, x0 forced to zero.
   always_comb begin
      rs1_rdata_o = regs_q[rs1_idx_i];
      rs2_rdata_o = regs_q[rs2_idx_i];
`ifdef REGFILE_WR_BYPASS_EN
      if (wb_we_i && (wb_rd_idx_i == rs1_idx_i)) rs1_rdata_o = wb_wdata_i;
      if (wb_we_i && (wb_rd_idx_i == rs2_idx_i)) rs2_rdata_o = wb_wdata_i;
`endif
      if (rs1_idx_i == '0) rs1_rdata_o = '0;
      if (rs2_idx_i == '0) rs2_rdata_o = '0;
   end

   // Next register array contents from the write-back port.
   always_comb begin
      regs_d = regs_q;
      if (wb_wr_en) regs_d[wb_rd_idx_i] = wb_wdata_i;
   end

   // Next busy vector: clear first so a same-index set (new producer) wins.
   always_comb begin
      busy_d = busy_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         if (wb_clr)  busy_d[wb_rd_idx_i]  = 1'b0;
         if (iss_set) busy_d[iss_rd_idx_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         busy_q <= '0;
         for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by randomized traffic,
// all compared against an array/bit-vector reference model of the register file.
module tb_regfile_sb;

`ifdef REGFILE_WR_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic [4:0]  rs1_idx_i, rs2_idx_i, iss_rd_idx_i, wb_rd_idx_i;
   logic        rs1_en_i, rs2_en_i, iss_valid_i, iss_rd_en_i, iss_long_i;
   logic        wb_we_i, wb_long_i, flush_i;
   logic [31:0] wb_wdata_i;
   logic [31:0] rs1_rdata_o, rs2_rdata_o;
   logic        stall_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];

   regfile_sb dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .rs1_idx_i    (rs1_idx_i),
      .rs1_en_i     (rs1_en_i),
      .rs2_idx_i    (rs2_idx_i),
      .rs2_en_i     (rs2_en_i),
      .rs1_rdata_o  (rs1_rdata_o),
      .rs2_rdata_o  (rs2_rdata_o),
      .iss_valid_i  (iss_valid_i),
      .iss_rd_idx_i (iss_rd_idx_i),
      .iss_rd_en_i  (iss_rd_en_i),
      .iss_long_i   (iss_long_i),
      .wb_we_i      (wb_we_i),
      .wb_rd_idx_i  (wb_rd_idx_i),
      .wb_wdata_i   (wb_wdata_i),
      .wb_long_i    (wb_long_i),
      .flush_i      (flush_i),
      .stall_o      (stall_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (Byp && wb_we_i && wb_rd_idx_i == idx) return wb_wdata_i;
      return m_regs[idx];
   endfunction

   // A register is a hazard if a load to it is pending and not retiring in a bypassed cycle.
   function automatic bit m_pending(input logic [4:0] idx);
      if (idx == 0 || !m_busy[idx]) return 1'b0;
      if (Byp && wb_we_i && wb_long_i && wb_rd_idx_i == idx) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_stall();
      if (!rst_n_i || flush_i) return 1'b0;
      return (rs1_en_i && m_pending(rs1_idx_i)) || (rs2_en_i && m_pending(rs2_idx_i))
             || (iss_valid_i && iss_rd_en_i && m_pending(iss_rd_idx_i));
   endfunction

   task automatic idle();
      rst_n_i = 1'b1; flush_i = 1'b0;
      rs1_idx_i = 0; rs1_en_i = 0; rs2_idx_i = 0; rs2_en_i = 0;
      iss_valid_i = 0; iss_rd_idx_i = 0; iss_rd_en_i = 0; iss_long_i = 0;
      wb_we_i = 0; wb_rd_idx_i = 0; wb_wdata_i = 0; wb_long_i = 0;
   endtask

   // Inputs already applied at the falling edge: compare outputs, then advance the model
   // across the rising edge and return at the next falling edge.
   task automatic step();
      bit st;
      #1;
      st = m_stall();
      check("rs1_rdata", rs1_rdata_o, m_read(rs1_idx_i));
      check("rs2_rdata", rs2_rdata_o, m_read(rs2_idx_i));
      check("stall", {31'h0, stall_o}, {31'h0, st});
      @(posedge clk_i);
      if (!rst_n_i) begin
         foreach (m_regs[i]) begin m_regs[i] = 0; m_busy[i] = 0; end
      end else begin
         if (wb_we_i && wb_rd_idx_i != 0) m_regs[wb_rd_idx_i] = wb_wdata_i;
         if (flush_i) begin
            foreach (m_busy[i]) m_busy[i] = 0;
         end else begin
            if (wb_we_i && wb_long_i) m_busy[wb_rd_idx_i] = 0;
            if (iss_valid_i && !st && iss_rd_en_i && iss_long_i && iss_rd_idx_i != 0)
               m_busy[iss_rd_idx_i] = 1;
         end
      end
      @(negedge clk_i);
   endtask

   initial begin
      idle();
      rst_n_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      foreach (m_regs[i]) begin m_regs[i] = 0; m_busy[i] = 0; end
      idle();

      // Reset clears written data.
      wb_we_i = 1; wb_rd_idx_i = 5; wb_wdata_i = 32'hDEAD; step();
      idle(); rst_n_i = 0; rs1_idx_i = 5; step();
      idle(); rs1_idx_i = 5; rs1_en_i = 1; #1;
      check("rst_x5", rs1_rdata_o, 32'h0);
      check("rst_stall", {31'h0, stall_o}, 32'h0);
      step();

      // x0 is hardwired zero and never busy.
      idle(); wb_we_i = 1; wb_rd_idx_i = 0; wb_wdata_i = 32'hFFFF_FFFF; step();
      idle(); rs1_en_i = 1; #1;
      check("x0_read", rs1_rdata_o, 32'h0);
      step();
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; step();
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; rs1_en_i = 1; #1;
      check("x0_stall", {31'h0, stall_o}, 32'h0);
      step();

      // Write then read x7.
      idle(); wb_we_i = 1; wb_rd_idx_i = 7; wb_wdata_i = 32'h1234; rs1_idx_i = 7; #1;
      check("wr_same_cyc", rs1_rdata_o, Byp ? 32'h1234 : 32'h0);
      step();
      idle(); rs1_idx_i = 7; #1;
      check("wr_next_cyc", rs1_rdata_o, 32'h1234);
      step();

      // Load-use on x3.
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 3; step();
      idle(); rs2_en_i = 1; rs2_idx_i = 3; #1;
      check("lu_stall0", {31'h0, stall_o}, 32'h1);
      step();
      idle(); rs2_en_i = 1; rs2_idx_i = 3; step();
      idle(); rs2_en_i = 1; rs2_idx_i = 3;
      wb_we_i = 1; wb_long_i = 1; wb_rd_idx_i = 3; wb_wdata_i = 32'hABCD; #1;
      check("lu_wb_stall", {31'h0, stall_o}, Byp ? 32'h0 : 32'h1);
      step();
      idle(); rs2_en_i = 1; rs2_idx_i = 3; #1;
      check("lu_after_stall", {31'h0, stall_o}, 32'h0);
      check("lu_after_data", rs2_rdata_o, 32'hABCD);
      step();

      // WAW on x4, then same-cycle set/clear on x9.
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 4; step();
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 4; #1;
      check("waw_stall", {31'h0, stall_o}, 32'h1);
      step();
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 9;
      wb_we_i = 1; wb_long_i = 1; wb_rd_idx_i = 9; wb_wdata_i = 32'h99; step();
      idle(); rs1_en_i = 1; rs1_idx_i = 9; #1;
      check("set_wins", {31'h0, stall_o}, 32'h1);
      step();

      // Flush drops busy bits but keeps the write-back.
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 3; step();
      idle(); iss_valid_i = 1; iss_rd_en_i = 1; iss_long_i = 1; iss_rd_idx_i = 8; step();
      idle(); flush_i = 1; rs1_en_i = 1; rs1_idx_i = 3;
      wb_we_i = 1; wb_rd_idx_i = 3; wb_wdata_i = 32'h55; #1;
      check("flush_stall", {31'h0, stall_o}, 32'h0);
      step();
      idle(); rs1_en_i = 1; rs1_idx_i = 3; rs2_en_i = 1; rs2_idx_i = 8; #1;
      check("flush_x3", rs1_rdata_o, 32'h55);
      check("flush_busy", {31'h0, stall_o}, 32'h0);
      step();

      // Randomized traffic over a small index range to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         idle();
         rst_n_i      = ($urandom_range(0, 199) != 0);
         flush_i      = ($urandom_range(0, 39) == 0);
         rs1_idx_i    = 5'($urandom_range(0, 7));
         rs2_idx_i    = 5'($urandom_range(0, 7));
         rs1_en_i     = 1'($urandom);
         rs2_en_i     = 1'($urandom);
         iss_valid_i  = 1'($urandom);
         iss_rd_en_i  = ($urandom_range(0, 3) != 0);
         iss_long_i   = 1'($urandom);
         iss_rd_idx_i = 5'($urandom_range(0, 7));
         wb_we_i      = 1'($urandom);
         wb_long_i    = 1'($urandom);
         wb_rd_idx_i  = 5'($urandom_range(0, 7));
         wb_wdata_i   = $urandom;
         if ($urandom_range(0, 15) == 0) begin
            rs1_idx_i = 5'($urandom_range(8, 31));
            wb_rd_idx_i = rs1_idx_i;
         end
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
